// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, requester FSM states and the
// response record returned per command.
package apb_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the APB ACCESS phase. A TIMEOUT_CYCLES
// value of 0 disables expiry entirely.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES) : '1;
  localparam logic [CW-1:0] LAST  = LIMIT - 1'b1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // High while the current low-ready cycle is the one that reaches the limit.
  assign expired = (TIMEOUT_CYCLES != 0) && (count >= LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single valid/ready commands into SETUP/ACCESS
// transfers and returns one registered response pulse per command.
module apb_master #(
  parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = apb_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write,
  output logic                  selx,
  output logic                  enable,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ready,
  input  logic                  slverr
);

  import apb_pkg::*;

  apb_state_e state;
  logic       timer_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == APB_SETUP),
    .inc    ((state == APB_ACCESS) && !ready),
    .expired(timer_expired)
  );

  // Response fields are a one-cycle pulse; they return to zero when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= APB_IDLE;
      cmd_ready   <= 1'b1;
      selx        <= 1'b0;
      enable      <= 1'b0;
      write       <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        APB_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= APB_SETUP;
            cmd_ready <= 1'b0;
            selx      <= 1'b1;
            write     <= cmd_write;
            addr      <= cmd_addr;
            if (cmd_write) begin
              wdata <= cmd_wdata;
            end
          end
        end
        APB_SETUP: begin
          state  <= APB_ACCESS;
          enable <= 1'b1;
        end
        APB_ACCESS: begin
          // Completion takes priority over a timer reaching its limit.
          if (ready) begin
            state     <= APB_IDLE;
            cmd_ready <= 1'b1;
            selx      <= 1'b0;
            enable    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= slverr;
            rsp_rdata <= write ? '0 : rdata;
          end else if (timer_expired) begin
            state       <= APB_IDLE;
            cmd_ready   <= 1'b1;
            selx        <= 1'b0;
            enable      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
        default: begin
          state     <= APB_IDLE;
          cmd_ready <= 1'b1;
          selx      <= 1'b0;
          enable    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized checks of apb_master against a transaction-level
// model of what each command should produce on the bus and response port.
module tb_apb_master;

  import apb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          write;
  logic          selx;
  logic          enable;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          slverr;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_wdata;
  logic [DW-1:0] rdata_drv;
  bit            mem_mode;
  apb_rsp_t      exp_q[$];

  always #5 clk = ~clk;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .addr       (addr),
    .wdata      (wdata),
    .write      (write),
    .selx       (selx),
    .enable     (enable),
    .rdata      (rdata),
    .ready      (ready),
    .slverr     (slverr)
  );

  // A memory-like slave for back-to-back traffic: data is a function of address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 22'h0} ^ 32'h1357_9BDF;
  endfunction

  assign rdata = mem_mode ? mem_word(addr) : rdata_drv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full command, acting as the slave; starts and ends at a negedge while idle.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int waits, input logic serr, input logic [DW-1:0] sdata);
    apb_rsp_t exp;
    int       n_access;
    bit       to;
    bit       done;
    to          = (TO != 0) && (waits >= TO);
    exp.timeout = to;
    exp.err     = to | serr;
    exp.rdata   = (to || wr) ? '0 : sdata;
    n_access    = to ? TO : waits + 1;

    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    ready     = 1'($urandom_range(0, 1));
    slverr    = 1'($urandom_range(0, 1));
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    if (wr) last_wdata = wd;
    chk("setup_selx", selx, 1);
    chk("setup_enable", enable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_addr", addr, a);
    chk("setup_write", write, wr);
    chk("setup_wdata", wdata, last_wdata);
    chk("setup_rsp_valid", rsp_valid, 0);
    ready  = 1'($urandom_range(0, 1));
    slverr = 1'($urandom_range(0, 1));
    for (int k = 1; k <= n_access; k++) begin
      @(negedge clk);
      chk("access_selx", selx, 1);
      chk("access_enable", enable, 1);
      chk("access_addr", addr, a);
      chk("access_write", write, wr);
      chk("access_wdata", wdata, last_wdata);
      chk("access_rsp_valid", rsp_valid, 0);
      done      = (k == waits + 1);
      ready     = done;
      slverr    = done ? serr : 1'($urandom_range(0, 1));
      rdata_drv = done ? sdata : $urandom;
    end
    @(negedge clk);
    ready  = 1'b0;
    slverr = 1'b0;
    chk("end_selx", selx, 0);
    chk("end_enable", enable, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp.rdata);
    chk("rsp_err", rsp_err, exp.err);
    chk("rsp_timeout", rsp_timeout, exp.timeout);
    chk("end_cmd_ready", cmd_ready, 1);
    chk("end_addr_hold", addr, a);
    @(negedge clk);
    chk("rsp_pulse_low", rsp_valid, 0);
  endtask

  initial begin
    apb_rsp_t      e;
    logic [AW-1:0] addrs[4];
    int            acc_cyc[4];
    int            idx;
    int            nrsp;
    bit            acc_pending;
    int            w;

    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    ready      = 1'b0;
    slverr     = 1'b0;
    rdata_drv  = '0;
    mem_mode   = 1'b0;
    last_wdata = '0;

    #12;
    chk("reset_selx", selx, 0);
    chk("reset_enable", enable, 0);
    chk("reset_addr", addr, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_write", write, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);

    // Directed cases from the test plan.
    run_xfer(1'b1, 10'h3A4, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    run_xfer(1'b0, 10'h010, 32'h0, 3, 1'b0, 32'hCAFEF00D);
    run_xfer(1'b0, 10'h155, 32'h0, 0, 1'b1, 32'h1234_5678);
    run_xfer(1'b0, 10'h2AA, 32'h0, TO, 1'b0, 32'h5555_AAAA);
    run_xfer(1'b0, 10'h2AB, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE);
    run_xfer(1'b1, 10'h001, 32'h0F0F_0F0F, TO + 5, 1'b0, 32'h0);

    // Randomized commands, mostly short waits with occasional near-limit ones.
    for (int i = 0; i < 12; i++) begin
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(0, 6));
      run_xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom, w,
               1'($urandom_range(0, 1)), $urandom);
    end

    // Back-to-back reads with cmd_valid held and a zero-wait slave.
    for (int i = 0; i < 4; i++) addrs[i] = AW'($urandom);
    mem_mode    = 1'b1;
    ready       = 1'b1;
    slverr      = 1'b0;
    idx         = 0;
    nrsp        = 0;
    acc_pending = 1'b0;
    for (int i = 0; i < 4; i++) acc_cyc[i] = -100;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = addrs[0];
    for (int n = 0; n < 16; n++) begin
      if (acc_pending) begin
        acc_pending = 1'b0;
        idx++;
        if (idx < 4) cmd_addr = addrs[idx];
        else cmd_valid = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("b2b_rsp_rdata", rsp_rdata, e.rdata);
          chk("b2b_rsp_err", rsp_err, e.err);
        end else begin
          chk("b2b_extra_rsp", 1, 0);
        end
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        acc_cyc[idx] = n;
        acc_pending  = 1'b1;
        e.rdata      = mem_word(addrs[idx]);
        e.err        = 1'b0;
        e.timeout    = 1'b0;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    chk("b2b_rsp_count", nrsp, 4);
    chk("b2b_accept_count", idx, 4);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    mem_mode  = 1'b0;
    ready     = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();

    // Reset while the slave is stalling in ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h0C3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_enable", enable, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_selx", selx, 0);
    chk("async_reset_enable", enable, 0);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    resetn     = 1'b1;
    last_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", rsp_valid, 0);
      chk("post_reset_selx", selx, 0);
    end
    run_xfer(1'b0, 10'h0C3, 32'h0, 2, 1'b0, 32'h7777_1111);
    run_xfer(1'b1, 10'h3FF, 32'hA5A5_5A5A, 1, 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that sits directly upstream of the APB bus and the bus assertion checker.
- Accepts single read/write commands on a valid/ready command port and sequences them as APB SETUP/ACCESS transfers.
- Returns one response per command, carrying read data and an error flag.
- A bounded wait-state timer aborts transfers whose slave never asserts ready.

Parameters:
- ADDR_WIDTH, 10, APB address width.
- DATA_WIDTH, 32, APB read/write data width.
- TIMEOUT_CYCLES, 16, number of ACCESS cycles with ready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  slverr sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by the timer.
- addr  out  ADDR_WIDTH  APB address.
- wdata  out  DATA_WIDTH  APB write data.
- write  out  1  APB direction.
- selx  out  1  APB select.
- enable  out  1  APB enable.
- rdata  in  DATA_WIDTH  APB read data.
- ready  in  1  APB slave ready.
- slverr  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset (async, resetn=0):
  - State goes to IDLE.
  - selx, enable, write, addr, wdata, rsp_* and the timer all go to 0.
  - cmd_ready is 1 once resetn deasserts.
- State machine:
  - IDLE: cmd_ready=1, selx=0, enable=0. On accept, capture cmd_write/cmd_addr/cmd_wdata into write/addr/wdata and go to SETUP.
  - SETUP (exactly one cycle): selx=1, enable=0, cmd_ready=0. Always goes to ACCESS.
  - ACCESS: selx=1, enable=1.
    - If ready=1: complete. Go to IDLE with selx=enable=0. Next cycle rsp_valid=1, rsp_err=slverr, rsp_rdata = write ? 0 : rdata (sampled on the ready cycle), rsp_timeout=0.
    - Else if the wait count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0): abort. Go to IDLE with selx=enable=0. Next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Else: increment the wait count.
- Timer:
  - Cleared on entry to ACCESS.
  - Counts ACCESS cycles with ready=0.
  - Width is $clog2(TIMEOUT_CYCLES+1), saturating; no wrap.
- Latency:
  - Accept at edge T gives SETUP at T+1 and ACCESS at T+2.
  - With zero wait states, rsp_valid is at T+3.
  - Minimum command spacing is 3 cycles, because IDLE is revisited between transfers.
- Stability:
  - addr, wdata and write are constant from SETUP through the last ACCESS cycle.
  - They hold their last value while IDLE; they never change while selx=1 and never go X after reset.
  - wdata holds its last value on reads.
- Boundaries:
  - No flow control on rsp; the consumer must always accept.
  - ready and slverr are ignored outside ACCESS.
  - A cmd_valid held while busy is not accepted until IDLE.
  - ready=1 on the same cycle the timer reaches its limit counts as completion, not timeout.
- Reset mid-transfer: the in-flight command is dropped silently and no response is issued.

Decomposition:
- Shared package apb_pkg:
  - ADDR_WIDTH and DATA_WIDTH default constants.
  - typedef enum apb_state_e {APB_IDLE, APB_SETUP, APB_ACCESS}.
  - Packed struct apb_rsp_t {rdata, err, timeout}.
- One natural sub-module: apb_wait_timer. It holds the parameterised saturating counter, with clear/inc inputs and an expired output.
- The FSM and capture registers stay in apb_master.

Test Plan:
- Write, zero wait: cmd write addr=0x3A4 wdata=0xDEADBEEF, slave ready in first ACCESS -> selx at T+1, enable at T+2, rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x010, ready at 4th ACCESS cycle with rdata=0xCAFEF00D -> addr/write stable through all ACCESS cycles, rsp_rdata=0xCAFEF00D, rsp_err=0.
- Slave error: read, ready=1 with slverr=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16, ready held 0 -> after 16 ACCESS cycles selx=0, rsp_valid with rsp_err=1, rsp_timeout=1; ready=1 on cycle 16 instead -> normal completion.
- Back-to-back: cmd_valid held high with 4 commands -> accepts exactly every 3 cycles with zero-wait slave, 4 responses in order, cmd_ready=0 in SETUP/ACCESS.
- Reset mid-ACCESS: resetn low during wait -> selx/enable/rsp_valid go 0 asynchronously, no response after release, next command runs normally.
